// File: rtl/obstacle_locator_if.sv
// obstacle_locator_if: raster timing, obstacle table read port and per-pixel obstacle result bus.
interface obstacle_locator_if #(
    parameter int BLOCK_LEN_WIDTH = 4,
    parameter int SCREEN_WIDTH    = 10,
    parameter int PHY_WIDTH       = 14,
    parameter int OBS_ID_WIDTH    = 4
);
    logic [SCREEN_WIDTH-1:0]    pixel_x;
    logic [SCREEN_WIDTH-1:0]    pixel_y;
    logic                       video_on;
    logic                       line_start;
    logic [SCREEN_WIDTH-1:0]    scan_line_y;
    logic [PHY_WIDTH-1:0]       camera_y;
    logic [OBS_ID_WIDTH-1:0]    tbl_addr;
    logic [PHY_WIDTH-1:0]       tbl_abs_x;
    logic [PHY_WIDTH-1:0]       tbl_abs_y;
    logic [BLOCK_LEN_WIDTH-1:0] tbl_len;
    logic                       tbl_valid;
    logic                       obstacle_on;
    logic [SCREEN_WIDTH-1:0]    obstacle_x_rom;
    logic [SCREEN_WIDTH-1:0]    obstacle_y_rom;
    logic [PHY_WIDTH-1:0]       obstacle_abs_pos_x;
    logic [PHY_WIDTH-1:0]       obstacle_abs_pos_y;
    logic [PHY_WIDTH-1:0]       obstacle_block_abs_y;
    logic                       scan_busy;
    logic                       scan_overrun;

    modport master (
        output pixel_x, pixel_y, video_on, line_start, scan_line_y, camera_y,
               tbl_abs_x, tbl_abs_y, tbl_len, tbl_valid,
        input  tbl_addr, obstacle_on, obstacle_x_rom, obstacle_y_rom,
               obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_block_abs_y,
               scan_busy, scan_overrun
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, line_start, scan_line_y, camera_y,
               tbl_abs_x, tbl_abs_y, tbl_len, tbl_valid,
        output tbl_addr, obstacle_on, obstacle_x_rom, obstacle_y_rom,
               obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_block_abs_y,
               scan_busy, scan_overrun
    );
endinterface

// File: rtl/obstacle_locator.sv
// obstacle_locator: scans the obstacle table in hblank for the next scanline and turns
// raster position into per-pixel obstacle hit and obstacle-local ROM coordinates.
module obstacle_locator #(
    parameter int OBSTACLE_WIDTH  = 10,
    parameter int BLOCK_LEN_WIDTH = 4,
    parameter int SCREEN_WIDTH    = 10,
    parameter int PHY_WIDTH       = 14,
    parameter int OBSTACLE_NUM    = 16,
    parameter int OBS_ID_WIDTH    = 4,
    parameter int V_ACTIVE        = 480
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    obstacle_locator_if.slave  bus
);
    localparam int PW = PHY_WIDTH + 1;
    localparam logic [OBS_ID_WIDTH-1:0] LAST_ID = OBS_ID_WIDTH'(OBSTACLE_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CHECK, S_COMMIT} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [OBS_ID_WIDTH-1:0]    r_tbl_addr;
    logic [OBS_ID_WIDTH-1:0]    w_chk_idx;
    logic [PHY_WIDTH-1:0]       r_abs_line;
    logic                       r_overrun;
    logic                       r_pnd_valid;
    logic [PHY_WIDTH-1:0]       r_pnd_x;
    logic [PHY_WIDTH-1:0]       r_pnd_y;
    logic [BLOCK_LEN_WIDTH-1:0] r_pnd_len;
    logic [OBS_ID_WIDTH-1:0]    r_pnd_idx;
    logic                       r_act_valid;
    logic [PHY_WIDTH-1:0]       r_act_x;
    logic [PHY_WIDTH-1:0]       r_act_y;
    logic [BLOCK_LEN_WIDTH-1:0] r_act_len;
    logic [OBS_ID_WIDTH-1:0]    r_act_idx;
    logic [PHY_WIDTH-1:0]       r_act_line;
    logic                       r_on;
    logic [SCREEN_WIDTH-1:0]    r_x_rom;
    logic [SCREEN_WIDTH-1:0]    r_y_rom;
    logic                       w_last;
    logic                       w_match;
    logic                       w_take;
    logic [PW-1:0]              w_y_hi;
    logic [PW-1:0]              w_px;
    logic [PW-1:0]              w_x_lo;
    logic [PW-1:0]              w_x_hi;
    logic                       w_hit;
    logic [SCREEN_WIDTH-1:0]    w_x_rom;
    logic [SCREEN_WIDTH-1:0]    w_y_rom;
    logic                       w_unused;

    // Table data lags the address by one cycle, so the entry under test is addr-1.
    assign w_chk_idx = r_tbl_addr - OBS_ID_WIDTH'(1);
    assign w_last    = (w_chk_idx == LAST_ID);
    assign w_y_hi    = PW'(bus.tbl_abs_y) + PW'(2 * OBSTACLE_WIDTH - 1);
    assign w_match   = bus.tbl_valid && (bus.tbl_len != '0) &&
                       (bus.tbl_abs_y <= r_abs_line) && (PW'(r_abs_line) <= w_y_hi);
    assign w_take    = !bus.line_start && (r_state == S_CHECK) && w_match && !r_pnd_valid;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = bus.line_start         ? S_READ :
                 (r_state == S_READ)    ? S_CHECK :
                 (r_state == S_CHECK)   ? (w_last ? S_COMMIT : S_CHECK) :
                                          S_IDLE;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tbl_addr  <= '0;
            r_abs_line  <= '0;
            r_overrun   <= 1'b0;
            r_pnd_valid <= 1'b0;
            r_pnd_x     <= '0;
            r_pnd_y     <= '0;
            r_pnd_len   <= '0;
            r_pnd_idx   <= '0;
        end else if (bus.line_start) begin
            r_tbl_addr  <= '0;
            r_abs_line  <= bus.camera_y + PHY_WIDTH'(V_ACTIVE - 1) - PHY_WIDTH'(bus.scan_line_y);
            r_overrun   <= r_overrun | (r_state != S_IDLE);
            r_pnd_valid <= 1'b0;
            r_pnd_x     <= '0;
            r_pnd_y     <= '0;
            r_pnd_len   <= '0;
            r_pnd_idx   <= '0;
        end else begin
            if (w_next == S_CHECK) r_tbl_addr <= r_tbl_addr + OBS_ID_WIDTH'(1);
            if (w_take) begin
                r_pnd_valid <= 1'b1;
                r_pnd_x     <= bus.tbl_abs_x;
                r_pnd_y     <= bus.tbl_abs_y;
                r_pnd_len   <= bus.tbl_len;
                r_pnd_idx   <= w_chk_idx;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_act_valid <= 1'b0;
            r_act_x     <= '0;
            r_act_y     <= '0;
            r_act_len   <= '0;
            r_act_idx   <= '0;
            r_act_line  <= '0;
        end else if (!bus.line_start && r_state == S_COMMIT) begin
            r_act_valid <= r_pnd_valid;
            r_act_x     <= r_pnd_x;
            r_act_y     <= r_pnd_y;
            r_act_len   <= r_pnd_len;
            r_act_idx   <= r_pnd_idx;
            r_act_line  <= r_abs_line;
        end
    end

    assign w_px    = PW'(bus.pixel_x);
    assign w_x_lo  = PW'(r_act_x);
    assign w_x_hi  = w_x_lo + PW'(r_act_len) * PW'(OBSTACLE_WIDTH) - PW'(1);
    assign w_hit   = bus.video_on && r_act_valid && (w_px >= w_x_lo) && (w_px <= w_x_hi);
    assign w_x_rom = SCREEN_WIDTH'(w_px - w_x_lo);
    assign w_y_rom = SCREEN_WIDTH'(r_act_y + PHY_WIDTH'(2 * OBSTACLE_WIDTH - 1) - r_act_line);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_on    <= 1'b0;
            r_x_rom <= '0;
            r_y_rom <= '0;
        end else begin
            r_on    <= w_hit;
            r_x_rom <= w_hit ? w_x_rom : '0;
            r_y_rom <= w_hit ? w_y_rom : '0;
        end
    end

    assign bus.tbl_addr             = r_tbl_addr;
    assign bus.obstacle_on          = r_on;
    assign bus.obstacle_x_rom       = r_x_rom;
    assign bus.obstacle_y_rom       = r_y_rom;
    assign bus.obstacle_abs_pos_x   = r_act_x;
    assign bus.obstacle_abs_pos_y   = r_act_y;
    assign bus.obstacle_block_abs_y = PHY_WIDTH'(r_act_idx);
    assign bus.scan_busy            = (r_state != S_IDLE);
    assign bus.scan_overrun         = r_overrun;
    assign w_unused                 = ^bus.pixel_y;
endmodule

// File: tb/tb_obstacle_locator.sv
// tb_obstacle_locator: randomized and directed checks of obstacle_locator against a
// first-match table model and interval arithmetic for the pixel path.
module tb_obstacle_locator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obstacle_locator_if bus ();
    obstacle_locator dut (.sys_clk(clk), .sys_rst(rst), .bus(bus.slave));

    int t_x[16], t_y[16], t_len[16], t_val[16];
    int e_val, e_x, e_y, e_len, e_idx, e_line;
    int n_total = 0, n_bad = 0;

    always @(posedge clk) begin
        bus.tbl_abs_x <= 14'(t_x[bus.tbl_addr]);
        bus.tbl_abs_y <= 14'(t_y[bus.tbl_addr]);
        bus.tbl_len   <= 4'(t_len[bus.tbl_addr]);
        bus.tbl_valid <= (t_val[bus.tbl_addr] != 0);
    end

    task automatic check(string tag, int got, int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int line_of(int cam, int sly);
        return (cam + 479 - sly) & 16383;
    endfunction

    function automatic void model_scan(int line);
        e_val = 0; e_x = 0; e_y = 0; e_len = 0; e_idx = 0; e_line = line;
        for (int i = 0; i < 16; i++)
            if (e_val == 0 && t_val[i] != 0 && t_len[i] != 0 && t_y[i] <= line && line <= t_y[i] + 19) begin
                e_val = 1; e_x = t_x[i]; e_y = t_y[i]; e_len = t_len[i]; e_idx = i;
            end
    endfunction

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) begin
            t_x[i] = 0; t_y[i] = 0; t_len[i] = 0; t_val[i] = 0;
        end
    endtask

    task automatic start_line(int cam, int sly);
        @(negedge clk);
        bus.camera_y = 14'(cam);
        bus.scan_line_y = 10'(sly);
        bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
    endtask

    task automatic finish_scan();
        int cnt = 0;
        while (bus.scan_busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_len", cnt, 18);
    endtask

    task automatic run_scan(int cam, int sly);
        start_line(cam, sly);
        finish_scan();
        model_scan(line_of(cam, sly));
    endtask

    task automatic check_active();
        check("abs_x", bus.obstacle_abs_pos_x, e_x);
        check("abs_y", bus.obstacle_abs_pos_y, e_y);
        check("blk", bus.obstacle_block_abs_y, e_idx);
    endtask

    task automatic pix(int px, int vo);
        int h;
        bus.pixel_x = 10'(px);
        bus.video_on = (vo != 0);
        @(negedge clk);
        h = (vo != 0 && e_val != 0 && px >= e_x && px <= e_x + e_len * 10 - 1) ? 1 : 0;
        check("on", bus.obstacle_on, h);
        check("x_rom", bus.obstacle_x_rom, h != 0 ? px - e_x : 0);
        check("y_rom", bus.obstacle_y_rom, h != 0 ? e_y + 19 - e_line : 0);
    endtask

    initial begin
        bus.pixel_x = '0; bus.pixel_y = '0; bus.video_on = 1'b0; bus.line_start = 1'b0;
        bus.scan_line_y = '0; bus.camera_y = '0;
        clear_tbl();
        model_scan(0);
        repeat (3) @(negedge clk);
        check("rst_busy", bus.scan_busy, 0);
        check("rst_ovr", bus.scan_overrun, 0);
        check("rst_on", bus.obstacle_on, 0);
        check("rst_addr", bus.tbl_addr, 0);
        check_active();
        rst = 1'b0;

        // basic hit
        t_x[0] = 200; t_y[0] = 95; t_len[0] = 3; t_val[0] = 1;
        run_scan(100, 479);
        check("basic_x", bus.obstacle_abs_pos_x, 200);
        check("basic_blk", bus.obstacle_block_abs_y, 0);
        check_active();
        pix(205, 1);
        check("basic_yrom", bus.obstacle_y_rom, 14);
        pix(229, 1);
        pix(230, 1);
        pix(199, 1);
        pix(205, 0);

        // priority
        clear_tbl();
        t_x[3] = 300; t_y[3] = 50; t_len[3] = 2; t_val[3] = 1;
        t_x[7] = 500; t_y[7] = 45; t_len[7] = 5; t_val[7] = 1;
        run_scan(60, 479);
        check("prio_blk", bus.obstacle_block_abs_y, 3);
        check_active();
        pix(310, 1);
        t_val[3] = 0;
        run_scan(60, 479);
        check("prio_blk2", bus.obstacle_block_abs_y, 7);
        check_active();
        pix(520, 1);

        // boundaries
        clear_tbl();
        t_x[0] = 100; t_y[0] = 1000; t_len[0] = 4; t_val[0] = 1;
        run_scan(1000, 479); pix(105, 1);
        check("bnd_lo", bus.obstacle_y_rom, 19);
        run_scan(1019, 479); pix(105, 1);
        run_scan(1020, 479); pix(105, 1); check_active();
        clear_tbl();
        t_x[0] = 10; t_y[0] = 500; t_len[0] = 0; t_val[0] = 1;
        t_x[1] = 20; t_y[1] = 500; t_len[1] = 5; t_val[1] = 0;
        t_x[2] = 30; t_y[2] = 500; t_len[2] = 1; t_val[2] = 1;
        run_scan(710, 200); check_active(); pix(35, 1); pix(12, 1); pix(39, 1); pix(40, 1);
        clear_tbl();
        t_x[4] = 600; t_y[4] = 16375; t_len[4] = 15; t_val[4] = 1;
        run_scan(16383, 479); check_active(); pix(749, 1); pix(750, 1);

        // randomized tables and lines
        for (int n = 0; n < 30; n++) begin
            int l, sly;
            clear_tbl();
            l = int'($urandom_range(0, 16383));
            for (int i = 0; i < 16; i++) begin
                t_val[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                t_len[i] = int'($urandom_range(0, 15));
                t_x[i] = int'($urandom_range(0, 900));
                t_y[i] = ($urandom_range(0, 2) != 0) ? ((l - int'($urandom_range(0, 25))) & 16383)
                                                      : int'($urandom_range(0, 16383));
            end
            sly = int'($urandom_range(0, 479));
            run_scan((l - (479 - sly)) & 16383, sly);
            check_active();
            for (int k = 0; k < 4; k++) begin
                int px;
                px = (e_val != 0) ? ((e_x + int'($urandom_range(0, e_len * 10 + 1)) - 1) & 1023)
                                  : int'($urandom_range(0, 1023));
                pix(px, ($urandom_range(0, 7) != 0) ? 1 : 0);
            end
        end

        // overrun: restart 5 cycles into a scan
        clear_tbl();
        t_x[1] = 100; t_y[1] = 2000; t_len[1] = 2; t_val[1] = 1;
        run_scan(2005, 479);
        check_active();
        t_x[5] = 400; t_y[5] = 3000; t_len[5] = 3; t_val[5] = 1;
        start_line(2005, 479);
        repeat (4) @(negedge clk);
        bus.camera_y = 14'd3010; bus.scan_line_y = 10'd479; bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
        check("ovr_set", bus.scan_overrun, 1);
        check("ovr_addr", bus.tbl_addr, 0);
        check_active();
        finish_scan();
        model_scan(3010);
        check_active();
        pix(410, 1);
        run_scan(2005, 479);
        check("ovr_sticky", bus.scan_overrun, 1);
        check_active();

        // reset mid-scan
        begin
            int k = 0;
            start_line(3010, 479);
            while (bus.tbl_addr != 4'd8 && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("reach8", bus.tbl_addr, 8);
            rst = 1'b1;
            #1;
            check("mrst_busy", bus.scan_busy, 0);
            check("mrst_ovr", bus.scan_overrun, 0);
            check("mrst_on", bus.obstacle_on, 0);
            check("mrst_addr", bus.tbl_addr, 0);
            check("mrst_x", bus.obstacle_abs_pos_x, 0);
            check("mrst_xrom", bus.obstacle_x_rom, 0);
            model_scan(0);
            e_val = 0;
            @(negedge clk);
            rst = 1'b0;
            pix(410, 1);
            check_active();
            run_scan(3010, 479);
            check_active();
            pix(410, 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/obstacle_locator.md
Name: obstacle_locator

Overview:
- Upstream feeder of the obstacle display/colouring stage: converts VGA raster position plus camera height into per-pixel obstacle hit and obstacle-local ROM coordinates.
- During horizontal blanking, a scan FSM walks the obstacle table and latches the one obstacle that covers the next scanline.
- During active video, a registered pixel path produces obstacle_on, obstacle_x_rom, obstacle_y_rom and the obstacle absolute-position fields consumed downstream.

Parameters:
- OBSTACLE_WIDTH, 10: block width in pixels; block height is 2*OBSTACLE_WIDTH.
- BLOCK_LEN_WIDTH, 4: width of the obstacle length field, in blocks (max 15).
- SCREEN_WIDTH, 10: width of pixel coordinates.
- PHY_WIDTH, 14: width of world coordinates.
- OBSTACLE_NUM, 16: number of table entries.
- OBS_ID_WIDTH, 4: table address width.
- V_ACTIVE, 480: active lines.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset.
- pixel_x  in  SCREEN_WIDTH  current pixel column.
- pixel_y  in  SCREEN_WIDTH  current pixel row.
- video_on  in  1  active-video qualifier.
- line_start  in  1  one-cycle pulse in hblank; starts a scan for scan_line_y.
- scan_line_y  in  SCREEN_WIDTH  screen row to be scanned (next row to display).
- camera_y  in  PHY_WIDTH  world y of the bottom screen row; sampled at line_start.
- tbl_addr  out  OBS_ID_WIDTH  obstacle table read address.
- tbl_abs_x  in  PHY_WIDTH  entry left x; valid 1 cycle after tbl_addr.
- tbl_abs_y  in  PHY_WIDTH  entry bottom y; valid 1 cycle after tbl_addr.
- tbl_len  in  BLOCK_LEN_WIDTH  entry length in blocks.
- tbl_valid  in  1  entry is populated.
- obstacle_on  out  1  current pixel lies inside the latched obstacle.
- obstacle_x_rom  out  SCREEN_WIDTH  pixel_x - abs_x.
- obstacle_y_rom  out  SCREEN_WIDTH  row inside the obstacle; 0 = top.
- obstacle_abs_pos_x  out  PHY_WIDTH  latched abs_x.
- obstacle_abs_pos_y  out  PHY_WIDTH  latched abs_y.
- obstacle_block_abs_y  out  PHY_WIDTH  latched table index, zero-extended.
- scan_busy  out  1  scan FSM is not IDLE.
- scan_overrun  out  1  sticky flag: a scan was restarted before it finished.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0; tbl_addr 0.
  - FSM goes to IDLE.
  - Active and pending entries are invalid; scan_overrun is cleared. Reset is the only clear for scan_overrun.
- World line:
  - abs_line = camera_y + (V_ACTIVE-1 - scan_line_y), computed modulo 2^PHY_WIDTH.
  - Captured in the cycle line_start is high.
- Hit test:
  - An entry matches when tbl_valid=1, tbl_len!=0, and abs_y <= abs_line <= abs_y + 2*OBSTACLE_WIDTH - 1.
  - The upper-bound sum is computed in PHY_WIDTH+1 bits so it does not wrap.
- FSM states: IDLE, READ, CHECK, COMMIT.
  - IDLE -> READ on line_start: tbl_addr=0; pending is cleared.
  - READ: issues the address; next state CHECK. From here on, one address is issued per cycle, pipelined.
  - CHECK: evaluates the entry returned for the previous address.
    - On the first match, pending latches abs_x, abs_y, len and index. Lower index wins; later matches are ignored.
    - Exits to COMMIT after the entry at index OBSTACLE_NUM-1 is checked.
    - Full scan takes OBSTACLE_NUM+2 cycles, line_start to COMMIT.
  - COMMIT: copies pending into the active registers in one cycle (invalid if nothing matched), then returns to IDLE.
- line_start while scan_busy: abort, restart from index 0 with the new line, set scan_overrun. Active registers are left unchanged.
- Pixel path, 1-cycle registered latency from pixel_x/video_on:
  - obstacle_on = video_on AND active valid AND abs_x <= pixel_x <= abs_x + len*OBSTACLE_WIDTH - 1. The comparison uses PHY_WIDTH+1 bits, with pixel_x zero-extended.
  - When obstacle_on=1: obstacle_x_rom = pixel_x - abs_x (range 0..len*W-1) and obstacle_y_rom = abs_y + 2W - 1 - abs_line (range 0..2W-1).
  - When obstacle_on=0: x_rom and y_rom are forced to 0.
  - obstacle_abs_pos_x, obstacle_abs_pos_y and obstacle_block_abs_y always mirror the active registers.
- Timing contract: line_start arrives at least OBSTACLE_NUM+3 sys_clk before the first active pixel of the row; COMMIT must never occur mid-row.

Test Plan:
- Basic hit:
  - Stimulus: camera_y=100, scan_line_y=479 (abs_line=100); entry0 abs_x=200, abs_y=95, len=3, valid.
  - Required: after COMMIT, pixel_x=205 with video_on -> next cycle obstacle_on=1, x_rom=5, y_rom=14, abs_pos_x=200, abs_pos_y=95, block_abs_y=0.
  - Required: pixel_x=229 -> on=1, x_rom=29.
  - Required: pixel_x=230 and pixel_x=199 -> on=0, x_rom=0, y_rom=0.
- Priority:
  - Stimulus: entries 3 and 7 both cover abs_line.
  - Required: block_abs_y=3. After invalidating entry 3 and rescanning -> block_abs_y=7.
- Boundaries:
  - Stimulus: abs_line=abs_y -> y_rom=19; abs_line=abs_y+19 -> y_rom=0; abs_line=abs_y+20 -> no hit.
  - Stimulus: an entry with tbl_len=0 or tbl_valid=0 -> never matches.
- Timing and overrun:
  - Required: scan_busy is high for exactly 18 cycles with OBSTACLE_NUM=16.
  - Stimulus: a second line_start 5 cycles into a scan.
  - Required: scan_overrun=1 and stays 1; the scan restarts from tbl_addr=0 and completes with the second line's result.
- Reset mid-scan:
  - Stimulus: assert sys_rst at index 8.
  - Required: all outputs 0 immediately, scan_busy=0, scan_overrun=0, obstacle_on=0 until the next completed scan.
- video_on low:
  - Stimulus: pixel inside the obstacle with video_on=0.
  - Required: obstacle_on=0.
